univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
Parametrised universal shift register. It generalises the single-bit serial-in/serial-out register to WIDTH bits and supports four modes: hold, shift right, shift left and parallel load. It has serial ports at both ends and a full parallel output. A built-in shift counter flags each completed WIDTH-bit word, so the block can act as a serialiser or deserialiser in the register library.

Parameters:
WIDTH, 8, register length in bits; legal range 2..32.
CNT_W, $clog2(WIDTH), bit_cnt width; derived, not overridden by users.

Ports:
clk  input  1  rising-edge clock
clr  input  1  asynchronous active-low reset; 0 clears all state immediately
en  input  1  clock enable; 0 freezes all state
mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
sin_msb  input  1  serial input entering bit WIDTH-1 on shift right
sin_lsb  input  1  serial input entering bit 0 on shift left
pdin  input  WIDTH  parallel load data
pdout  output  WIDTH  current register contents q
sout_lsb  output  1  q[0]; serial output for shift right
sout_msb  output  1  q[WIDTH-1]; serial output for shift left
bit_cnt  output  CNT_W  shifts completed in the current word, 0..WIDTH-1
word_done  output  1  registered one-cycle pulse after the WIDTH-th shift of a word

Behaviour:
- Reset: clr=0, asynchronous. q=0, bit_cnt=0, word_done=0, so pdout=0 and sout_lsb=sout_msb=0. State stays cleared while clr=0. Release is synchronous in effect: the first update occurs on the first rising clk edge with clr=1.
- All updates occur on the rising clk edge, only when clr=1 and en=1.
- en=0: q and bit_cnt hold, and word_done is driven 0 on that edge.
- mode 00: q holds, bit_cnt holds, word_done<=0.
- mode 01: q <= {sin_msb, q[WIDTH-1:1]}.
- mode 10: q <= {q[WIDTH-2:0], sin_lsb}.
- mode 11: q <= pdin, bit_cnt <= 0, word_done <= 0. Load starts a new word.
- Shift counting (modes 01 and 10):
  - bit_cnt<WIDTH-1: bit_cnt increments and word_done<=0.
  - bit_cnt==WIDTH-1: bit_cnt wraps to 0 and word_done<=1 for exactly one cycle.
- Changing direction mid-word (01 to 10 or back) does not reset bit_cnt. Counting continues.
- Back-to-back words under continuous shifting: word_done pulses every WIDTH enabled shift cycles with no gap.
- Gaps in a word: en=0 or mode 00 cycles pause the count. The word completes after WIDTH shift edges, not WIDTH clocks.
- Outputs are continuous views of registered state: pdout, sout_lsb, sout_msb and bit_cnt are not registered separately. No combinational path exists from inputs to outputs.
- Latency: a serial bit applied before edge N appears at the far serial output after WIDTH shift edges.
- Reset mid-word: clr=0 at any time clears q, bit_cnt and word_done asynchronously. Any in-flight word_done pulse is truncated.
- Unused serial input for the active direction is ignored.
- X on mode while en=1 is illegal. The bench flags it and the design behaviour is undefined.

Test Plan:
- Reset: drive clr=0 mid-operation with q=8'h5A and bit_cnt=3 -> pdout=8'h00, bit_cnt=0 and word_done=0 before the next clk edge; state holds at 0 until clr=1.
- Load then shift right: load pdin=8'hA5, then 8 cycles of mode 01 with sin_msb=0 -> sout_lsb sequence before each edge is 1,0,1,0,0,1,0,1; pdout=8'h00 at the end; word_done high for exactly the cycle after the 8th shift.
- Shift left deserialise: from reset, 8 cycles of mode 10 with sin_lsb sequence 1,1,0,0,1,0,1,1 -> pdout=8'hCB; bit_cnt steps 1..7 then 0; one word_done pulse.
- Gaps: shift right 3 times, then en=0 for 2 cycles, then mode 00 for 1 cycle, then 5 more shifts -> bit_cnt holds at 3 during the gaps; word_done asserts only after the 8th shift, i.e. 11 clocks after the first shift.
- Load mid-word and direction change: after 5 shifts, load 8'h0F -> bit_cnt=0 and no word_done; then 4 right shifts and 4 left shifts with both serial inputs at 0 -> pdout=8'h00 and word_done after the 8th shift.
- Continuous streaming: 24 consecutive mode-01 cycles -> word_done pulses exactly 3 times, 8 cycles apart; WIDTH=4 re-run -> pulses every 4 cycles and bit_cnt is 2 bits wide.

Source files
------------

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with per-word shift counter
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic [WIDTH-1:0] pdin,
    output logic [WIDTH-1:0] pdout,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             word_done
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    // Last count value of a word; the shift that leaves this value closes the word.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q;
    logic [CNT_W-1:0] cnt;
    logic             done;

    // Data register: hold, shift in from either end, or parallel load.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q <= '0;
        end else if (en) begin
            case (mode)
                MODE_RIGHT: q <= {sin_msb, q[WIDTH-1:1]};
                MODE_LEFT:  q <= {q[WIDTH-2:0], sin_lsb};
                MODE_LOAD:  q <= pdin;
                default:    q <= q;
            endcase
        end
    end

    // Word counter: counts shift edges in either direction, load restarts the word,
    // and the wrap from the last count produces a single-cycle done pulse.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (!en) begin
            done <= 1'b0;
        end else begin
            case (mode)
                MODE_RIGHT, MODE_LEFT: begin
                    if (cnt == CNT_LAST) begin
                        cnt  <= '0;
                        done <= 1'b1;
                    end else begin
                        cnt  <= cnt + CNT_W'(1);
                        done <= 1'b0;
                    end
                end
                MODE_LOAD: begin
                    cnt  <= '0;
                    done <= 1'b0;
                end
                MODE_HOLD: begin
                    done <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

    // Outputs are plain views of the registered state.
    assign pdout     = q;
    assign sout_lsb  = q[0];
    assign sout_msb  = q[WIDTH-1];
    assign bit_cnt   = cnt;
    assign word_done = done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - scoreboard bench for univ_shift_reg (WIDTH 8 and 4)
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       sin_msb = 1'b0;
    logic       sin_lsb = 1'b0;
    logic [7:0] pdin = 8'h00;

    logic [7:0] pdout;
    logic       sout_lsb, sout_msb;
    logic [2:0] bit_cnt;
    logic       word_done;

    logic [3:0] pdout4;
    logic       sout_lsb4, sout_msb4;
    logic [1:0] bit_cnt4;
    logic       word_done4;

    univ_shift_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .clr(clr), .en(en), .mode(mode),
        .sin_msb(sin_msb), .sin_lsb(sin_lsb), .pdin(pdin),
        .pdout(pdout), .sout_lsb(sout_lsb), .sout_msb(sout_msb),
        .bit_cnt(bit_cnt), .word_done(word_done)
    );

    univ_shift_reg #(.WIDTH(4)) dut4 (
        .clk(clk), .clr(clr), .en(en), .mode(mode),
        .sin_msb(sin_msb), .sin_lsb(sin_lsb), .pdin(pdin[3:0]),
        .pdout(pdout4), .sout_lsb(sout_lsb4), .sout_msb(sout_msb4),
        .bit_cnt(bit_cnt4), .word_done(word_done4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        logic [7:0]  pd;
        logic [31:0] cnt;
        logic        wd;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    event chk_ev;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] fill8 [8] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    logic [7:0] fill4 [4] = '{8'h08, 8'h0C, 8'h0E, 8'h0F};

    task automatic push(input int sel, input logic [7:0] xpd, input int xcnt,
                        input logic xwd, input string tag);
        exp_t e;
        e.sel = sel;
        e.pd  = xpd;
        e.cnt = xcnt;
        e.wd  = xwd;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // One clocked vector: inputs applied at the falling edge, expected state after the next rising edge.
    task automatic step(input int sel, input logic e, input logic [1:0] m,
                        input logic smsb, input logic slsb, input logic [7:0] pd_in,
                        input logic [7:0] xpd, input int xcnt, input logic xwd,
                        input string tag);
        @(negedge clk);
        en      = e;
        mode    = m;
        sin_msb = smsb;
        sin_lsb = slsb;
        pdin    = pd_in;
        push(sel, xpd, xcnt, xwd, tag);
    endtask

    // Asynchronous clear in the middle of a cycle, checked before any clock edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        clr = 1'b0;
        push(0, 8'h00, 0, 1'b0, tag);
        push(1, 8'h00, 0, 1'b0, tag);
        -> chk_ev;
    endtask

    task automatic release_reset();
        @(negedge clk);
        en  = 1'b0;
        clr = 1'b1;
    endtask

    // Monitor: compares every pending expectation shortly after a clock edge or an async check.
    initial begin
        exp_t        e;
        logic [31:0] ac;
        logic        ok;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (e.sel == 0) begin
                    ac = 32'(bit_cnt);
                    ok = (pdout === e.pd) && (ac === e.cnt) && (word_done === e.wd) &&
                         (sout_lsb === e.pd[0]) && (sout_msb === e.pd[7]);
                    if (!ok) begin
                        errors++;
                        $display("FAIL %s w8: pdout=%h bit_cnt=%0d word_done=%b sout_lsb=%b sout_msb=%b, expected pdout=%h bit_cnt=%0d word_done=%b",
                                 e.tag, pdout, bit_cnt, word_done, sout_lsb, sout_msb, e.pd, e.cnt, e.wd);
                    end
                end else begin
                    ac = 32'(bit_cnt4);
                    ok = (pdout4 === e.pd[3:0]) && (ac === e.cnt) && (word_done4 === e.wd) &&
                         (sout_lsb4 === e.pd[0]) && (sout_msb4 === e.pd[3]);
                    if (!ok) begin
                        errors++;
                        $display("FAIL %s w4: pdout=%h bit_cnt=%0d word_done=%b sout_lsb=%b sout_msb=%b, expected pdout=%h bit_cnt=%0d word_done=%b",
                                 e.tag, pdout4, bit_cnt4, word_done4, sout_lsb4, sout_msb4, e.pd[3:0], e.cnt, e.wd);
                    end
                end
            end
        end
    end

    // Mode must be known whenever the register is enabled.
    always @(posedge clk) begin
        if (clr && en && $isunknown(mode)) begin
            errors++;
            $display("FAIL mode_x: mode=%b while en=1, required a known value", mode);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required stimulus to complete");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        push(0, 8'h00, 0, 1'b0, "reset_init");
        push(1, 8'h00, 0, 1'b0, "reset_init");
        -> chk_ev;
        release_reset();

        // Build q=5A with bit_cnt=3, then clear mid-word.
        step(0, 1, 2'b11, 0, 0, 8'h0B, 8'h0B, 0, 0, "pre_load");
        step(0, 1, 2'b10, 0, 0, 8'h00, 8'h16, 1, 0, "pre_sl1");
        step(0, 1, 2'b10, 0, 1, 8'h00, 8'h2D, 2, 0, "pre_sl2");
        step(0, 1, 2'b10, 0, 0, 8'h00, 8'h5A, 3, 0, "pre_sl3");
        async_reset("reset_mid");
        step(0, 1, 2'b11, 0, 0, 8'hFF, 8'h00, 0, 0, "reset_hold1");
        step(0, 1, 2'b01, 1, 1, 8'hFF, 8'h00, 0, 0, "reset_hold2");
        release_reset();

        // Load A5, serialise out to the right.
        step(0, 1, 2'b11, 0, 0, 8'hA5, 8'hA5, 0, 0, "sr_load");
        step(0, 1, 2'b01, 0, 0, 8'h00, 8'h52, 1, 0, "sr_1");
        step(0, 1, 2'b01, 0, 0, 8'h00, 8'h29, 2, 0, "sr_2");
        step(0, 1, 2'b01, 0, 0, 8'h00, 8'h14, 3, 0, "sr_3");
        step(0, 1, 2'b01, 0, 0, 8'h00, 8'h0A, 4, 0, "sr_4");
        step(0, 1, 2'b01, 0, 0, 8'h00, 8'h05, 5, 0, "sr_5");
        step(0, 1, 2'b01, 0, 0, 8'h00, 8'h02, 6, 0, "sr_6");
        step(0, 1, 2'b01, 0, 0, 8'h00, 8'h01, 7, 0, "sr_7");
        step(0, 1, 2'b01, 0, 0, 8'h00, 8'h00, 0, 1, "sr_8");
        step(0, 1, 2'b00, 0, 0, 8'h00, 8'h00, 0, 0, "sr_hold");

        // Deserialise from the left; sin_msb is unused and held high.
        async_reset("reset_sl");
        release_reset();
        step(0, 1, 2'b10, 1, 1, 8'h00, 8'h01, 1, 0, "sl_1");
        step(0, 1, 2'b10, 1, 1, 8'h00, 8'h03, 2, 0, "sl_2");
        step(0, 1, 2'b10, 1, 0, 8'h00, 8'h06, 3, 0, "sl_3");
        step(0, 1, 2'b10, 1, 0, 8'h00, 8'h0C, 4, 0, "sl_4");
        step(0, 1, 2'b10, 1, 1, 8'h00, 8'h19, 5, 0, "sl_5");
        step(0, 1, 2'b10, 1, 0, 8'h00, 8'h32, 6, 0, "sl_6");
        step(0, 1, 2'b10, 1, 1, 8'h00, 8'h65, 7, 0, "sl_7");
        step(0, 1, 2'b10, 1, 1, 8'h00, 8'hCB, 0, 1, "sl_8");
        step(0, 1, 2'b00, 0, 0, 8'h00, 8'hCB, 0, 0, "sl_hold");

        // Gaps: en=0 and mode 00 pause the word.
        step(0, 1, 2'b01, 1, 0, 8'h00, 8'hE5, 1, 0, "gap_1");
        step(0, 1, 2'b01, 1, 0, 8'h00, 8'hF2, 2, 0, "gap_2");
        step(0, 1, 2'b01, 1, 0, 8'h00, 8'hF9, 3, 0, "gap_3");
        step(0, 0, 2'b01, 1, 0, 8'h00, 8'hF9, 3, 0, "gap_en0a");
        step(0, 0, 2'b01, 1, 0, 8'h00, 8'hF9, 3, 0, "gap_en0b");
        step(0, 1, 2'b00, 1, 0, 8'h00, 8'hF9, 3, 0, "gap_hold");
        step(0, 1, 2'b01, 0, 0, 8'h00, 8'h7C, 4, 0, "gap_4");
        step(0, 1, 2'b01, 0, 0, 8'h00, 8'h3E, 5, 0, "gap_5");
        step(0, 1, 2'b01, 0, 0, 8'h00, 8'h1F, 6, 0, "gap_6");
        step(0, 1, 2'b01, 0, 0, 8'h00, 8'h0F, 7, 0, "gap_7");
        step(0, 1, 2'b01, 0, 0, 8'h00, 8'h07, 0, 1, "gap_8");
        step(0, 1, 2'b00, 0, 0, 8'h00, 8'h07, 0, 0, "gap_end");

        // Load mid-word, then change direction mid-word.
        step(0, 1, 2'b10, 0, 1, 8'h00, 8'h0F, 1, 0, "mid_1");
        step(0, 1, 2'b10, 0, 1, 8'h00, 8'h1F, 2, 0, "mid_2");
        step(0, 1, 2'b10, 0, 1, 8'h00, 8'h3F, 3, 0, "mid_3");
        step(0, 1, 2'b10, 0, 1, 8'h00, 8'h7F, 4, 0, "mid_4");
        step(0, 1, 2'b10, 0, 1, 8'h00, 8'hFF, 5, 0, "mid_5");
        step(0, 1, 2'b11, 0, 0, 8'h0F, 8'h0F, 0, 0, "mid_load");
        step(0, 1, 2'b01, 0, 0, 8'h00, 8'h07, 1, 0, "dir_r1");
        step(0, 1, 2'b01, 0, 0, 8'h00, 8'h03, 2, 0, "dir_r2");
        step(0, 1, 2'b01, 0, 0, 8'h00, 8'h01, 3, 0, "dir_r3");
        step(0, 1, 2'b01, 0, 0, 8'h00, 8'h00, 4, 0, "dir_r4");
        step(0, 1, 2'b10, 0, 0, 8'h00, 8'h00, 5, 0, "dir_l1");
        step(0, 1, 2'b10, 0, 0, 8'h00, 8'h00, 6, 0, "dir_l2");
        step(0, 1, 2'b10, 0, 0, 8'h00, 8'h00, 7, 0, "dir_l3");
        step(0, 1, 2'b10, 0, 0, 8'h00, 8'h00, 0, 1, "dir_l4");

        // Continuous streaming: three back-to-back words.
        for (int i = 1; i <= 24; i++) begin
            step(0, 1, 2'b01, 1, 0, 8'h00, (i >= 8) ? 8'hFF : fill8[i-1],
                 i % 8, (i % 8) == 0, "stream8");
        end

        // Clear lands while the final word_done pulse is still high.
        async_reset("reset_trunc");
        release_reset();

        // WIDTH=4 instance: pulses every 4 shifts.
        for (int i = 1; i <= 12; i++) begin
            step(1, 1, 2'b01, 1, 0, 8'h00, (i >= 4) ? 8'h0F : fill4[i-1],
                 i % 4, (i % 4) == 0, "stream4");
        end

        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
